// File: rtl/niosii_system_cpu_div_cell.sv
// Iterative 32-bit signed/unsigned divider: restoring algorithm, one quotient bit per clock.
// Latency: 33 clocks from the accepting start edge to the one-cycle done pulse, operand independent.
// Backpressure: none; start is ignored while busy, results hold until the next division completes.
module niosii_system_cpu_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_cell_result,
    output logic [DATA_W-1:0] A_div_cell_remainder,
    output logic              A_div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]        state;
    logic [4:0]        count;
    logic [DATA_W-1:0] rem_acc;      // partial remainder; its 33rd bit is always zero between steps
    logic [DATA_W-1:0] quo_acc;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] dividend_raw; // reported as the remainder on divide by zero
    logic              q_neg;
    logic              r_neg;
    logic              zero;

    logic [DATA_W-1:0] src1_mag;
    logic [DATA_W-1:0] src2_mag;
    logic [DATA_W:0]   trial;
    logic              trial_ge;
    logic [DATA_W-1:0] trial_diff;

    // Operand magnitudes and the per-iteration trial subtraction
    always_comb begin
        src1_mag   = (A_div_signed && A_div_src1[DATA_W-1]) ? (~A_div_src1 + 1'b1) : A_div_src1;
        src2_mag   = (A_div_signed && A_div_src2[DATA_W-1]) ? (~A_div_src2 + 1'b1) : A_div_src2;
        trial      = {rem_acc, quo_acc[DATA_W-1]};
        trial_ge   = (trial >= {1'b0, divisor});
        // The true difference is below the divisor whenever it is kept, so 32 bits are exact
        trial_diff = trial[DATA_W-1:0] - divisor;
    end

    assign A_div_busy = (state != ST_IDLE);

    // Control FSM, datapath iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            count                <= '0;
            rem_acc              <= '0;
            quo_acc              <= '0;
            divisor              <= '0;
            dividend_raw         <= '0;
            q_neg                <= 1'b0;
            r_neg                <= 1'b0;
            zero                 <= 1'b0;
            A_div_done           <= 1'b0;
            A_div_cell_result    <= '0;
            A_div_cell_remainder <= '0;
            A_div_by_zero        <= 1'b0;
        end else begin
            A_div_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (A_div_start) begin
                        state         <= ST_DIV;
                        count         <= '0;
                        rem_acc       <= '0;
                        quo_acc       <= src1_mag;
                        divisor       <= src2_mag;
                        dividend_raw  <= A_div_src1;
                        q_neg         <= A_div_signed & (A_div_src1[DATA_W-1] ^ A_div_src2[DATA_W-1]);
                        r_neg         <= A_div_signed & A_div_src1[DATA_W-1];
                        zero          <= (A_div_src2 == '0);
                        A_div_by_zero <= 1'b0;
                    end
                end
                ST_DIV: begin
                    if (trial_ge) begin
                        rem_acc <= trial_diff;
                        quo_acc <= {quo_acc[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_acc <= trial[DATA_W-1:0];
                        quo_acc <= {quo_acc[DATA_W-2:0], 1'b0};
                    end
                    if (count == 5'd31) begin
                        state <= ST_FIX;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                ST_FIX: begin
                    state      <= ST_IDLE;
                    A_div_done <= 1'b1;
                    if (zero) begin
                        A_div_cell_result    <= '1;
                        A_div_cell_remainder <= dividend_raw;
                        A_div_by_zero        <= 1'b1;
                    end else begin
                        A_div_cell_result    <= q_neg ? (~quo_acc + 1'b1) : quo_acc;
                        A_div_cell_remainder <= r_neg ? (~rem_acc + 1'b1) : rem_acc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_niosii_system_cpu_div_cell.sv
module tb_niosii_system_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    niosii_system_cpu_div_cell #(.DATA_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .A_div_start          (start),
        .A_div_signed         (sgn),
        .A_div_src1           (src1),
        .A_div_src2           (src2),
        .A_div_busy           (busy),
        .A_div_done           (done),
        .A_div_cell_result    (result),
        .A_div_cell_remainder (remainder),
        .A_div_by_zero        (by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ebz;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: division by plain 64-bit arithmetic (SV % truncates toward zero like DIV)
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic bz);
        longint sa, sb, lq, lr;
        bz = (b == 32'd0);
        if (bz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one start pulse, then wait for done; lat counts edges from the start edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int bcnt);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; sgn = $urandom_range(0, 1);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done at 33", lat);
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic chk_timing);
        int lat, bcnt;
        logic [31:0] eq, er;
        logic ebz;
        model(a, b, s, eq, er, ebz);
        do_op(a, b, s, lat, bcnt);
        chk({name, "_q"}, result, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_bz"}, {31'd0, by_zero}, {31'd0, ebz});
        if (chk_timing) begin
            chk({name, "_lat"}, lat, 33);
            chk({name, "_busy"}, bcnt, 33);
        end
    endtask

    initial begin
        logic [31:0] eq, er, hq, hr;
        logic ebz;
        int lat, bcnt, dcnt;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[4] = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[5] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        vecs[8] = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0};

        reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", result, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_bz", {31'd0, by_zero}, 32'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcnt);
            chk($sformatf("vec%0d_q", i), result, vecs[i].eq);
            chk($sformatf("vec%0d_r", i), remainder, vecs[i].er);
            chk($sformatf("vec%0d_bz", i), {31'd0, by_zero}, {31'd0, vecs[i].ebz});
            chk($sformatf("vec%0d_lat", i), lat, 33);
            chk($sformatf("vec%0d_busy", i), bcnt, 33);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), {31'd0, done}, 32'd0);
        end

        // Divide-by-zero flag clears when the next division starts
        do_op(32'h1234_5678, 32'd0, 1'b0, lat, bcnt);
        @(negedge clk);
        src1 = 32'd5; src2 = 32'd1; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bz_clear", {31'd0, by_zero}, 32'd0);
        chk("hold_q_during_div", result, 32'hFFFF_FFFF);
        while (!done) @(negedge clk);
        chk("after_bz_q", result, 32'd5);

        // Back-to-back: 9/3, then start 10/4 in the done cycle
        do_op(32'd9, 32'd3, 1'b0, lat, bcnt);
        chk("b2b_first_q", result, 32'd3);
        src1 = 32'd10; src2 = 32'd4; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; hq = result; hr = remainder;
        while (!done && lat < 100) begin
            if (result !== 32'd3 || remainder !== 32'd0) begin
                hq = result; hr = remainder;
            end
            @(negedge clk);
            lat++;
        end
        chk("b2b_hold_q", hq, 32'd3);
        chk("b2b_hold_r", hr, 32'd0);
        chk("b2b_lat", lat, 33);
        chk("b2b_q", result, 32'd2);
        chk("b2b_r", remainder, 32'd2);

        // Start 100/7, restart attempt at E10, reset at E20: nothing completes
        @(negedge clk);
        src1 = 32'd100; src2 = 32'd7; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) begin src1 = 32'd50; src2 = 32'd5; start = 1'b1; end
            if (k == 11) start = 1'b0;
            if (k == 20) reset = 1'b1;
            @(negedge clk);
            if (done) dcnt++;
        end
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_q", result, 32'd0);
        chk("mid_rst_r", remainder, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("mid_rst_no_done", dcnt, 0);
        check_op("after_rst", 32'd50, 32'd5, 1'b0, 1'b1);
        chk("after_rst_q_exact", result, 32'd10);

        // Start coinciding with reset is lost
        @(negedge clk);
        src1 = 32'd77; src2 = 32'd7; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("rst_start_no_done", dcnt, 0);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            check_op($sformatf("rnd%0d", i), a, b, $urandom_range(0, 1), (i % 8) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
